// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The IM occupies CPU byte addresses 0x0000_3000 + 4*i for word index i.
package im_loader_pkg;

  localparam int IM_WORDS = 256;
  localparam int WADDR_W  = 8;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_LEN_LO = 3'd2,
    LD_DATA   = 3'd3,
    LD_CHK    = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERR    = 3'd6
  } ld_state_e;

endpackage

// File: rtl/im_loader_be_word_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24].
// word_valid_o pulses combinationally with the 4th accepted byte, so the
// caller can register the completed word on that same edge.
module be_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;

  // Next lane/accumulator: shift each byte in from the right.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clear_i) begin
      lane_d = 2'd0;
      acc_d  = 24'd0;
    end else if (byte_valid_i) begin
      acc_d  = {acc_q[15:0], byte_i};
      lane_d = lane_q + 2'd1;
    end
  end

  // Lane counter and the three already-received bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      acc_q  <= 24'd0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

  assign word_valid_o = byte_valid_i && (lane_q == 2'd3) && !clear_i;
  assign word_o       = {acc_q, byte_i};

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: parses LEN_HI, LEN_LO, 4*N data bytes and an
// XOR checksum byte from a valid/ready byte stream, writes packed words to
// IM addresses 0..N-1 and holds the core in reset until a load completes.
// Handshake: a byte transfers on a posedge where in_valid && in_ready; the
// source keeps in_data stable while in_valid is high and in_ready is low.
module im_loader
  import im_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [WADDR_W-1:0] im_waddr,
  output logic [31:0]        im_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output ld_state_e          dbg_state
);

  ld_state_e state_q, state_d;

  logic [7:0]         len_hi_q;
  logic [15:0]        len_q;
  logic [WADDR_W:0]   widx_q;
  logic [7:0]         chk_q;
  logic               im_we_q;
  logic [WADDR_W-1:0] im_waddr_q;
  logic [31:0]        im_wdata_q;
  logic               hold_q;
  logic               done_q;
  logic               err_q;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_new;
  logic        last_word;
  logic        word_valid;
  logic [31:0] word;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q == LD_IDLE || state_q == LD_DONE || state_q == LD_ERR);
  assign len_new   = {len_hi_q, in_data};
  assign last_word = (16'(widx_q) == (len_q - 16'd1));

  be_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .byte_valid_i (accept && (state_q == LD_DATA)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state logic and ready; no byte is taken during an IM write cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      LD_IDLE: if (start) state_d = LD_LEN_HI;
      LD_LEN_HI: begin
        in_ready = !im_we_q;
        if (accept) state_d = LD_LEN_LO;
      end
      LD_LEN_LO: begin
        in_ready = !im_we_q;
        if (accept) begin
          if (len_new == 16'd0)                 state_d = LD_CHK;
          else if (len_new > 16'(IM_WORDS))     state_d = LD_ERR;
          else                                  state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        in_ready = !im_we_q;
        if (word_valid && last_word) state_d = LD_CHK;
      end
      LD_CHK: begin
        in_ready = !im_we_q;
        if (accept) state_d = (in_data == chk_q) ? LD_DONE : LD_ERR;
      end
      LD_DONE, LD_ERR: if (start) state_d = LD_LEN_HI;
      default: state_d = LD_IDLE;
    endcase
  end

  // State register, length capture, checksum, write port and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      widx_q     <= '0;
      chk_q      <= 8'd0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= 32'd0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      im_we_q <= word_valid;
      if (word_valid) begin
        im_waddr_q <= widx_q[WADDR_W-1:0];
        im_wdata_q <= word;
        widx_q     <= widx_q + 1'b1;
      end
      if (accept && state_q == LD_LEN_HI) len_hi_q <= in_data;
      if (accept && state_q == LD_LEN_LO) len_q    <= len_new;
      if (accept && state_q == LD_DATA)   chk_q    <= chk_q ^ in_data;
      if (start_ok) begin
        widx_q <= '0;
        chk_q  <= 8'd0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        hold_q <= 1'b1;
      end
      if (state_d == LD_DONE && state_q != LD_DONE) begin
        done_q <= 1'b1;
        hold_q <= 1'b0;
      end
      if (state_d == LD_ERR && state_q != LD_ERR) err_q <= 1'b1;
    end
  end

  assign im_we     = im_we_q;
  assign im_waddr  = im_waddr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected IM writes go into a queue when a
// frame is driven; a monitor pops and compares on every im_we cycle.
module tb_im_loader;
  import im_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  ld_state_e   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] exp_q[$];

  im_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", im_waddr, im_wdata);
      end else begin
        check("im_write", {im_waddr, im_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got in_ready 0 after %0d cycles, expected 1", waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic check_status(input string tag, input logic done_e, input logic err_e,
                              input logic hold_e, input ld_state_e st_e);
    @(negedge clk);
    check({tag, "_done"},  40'(load_done), 40'(done_e));
    check({tag, "_err"},   40'(load_err),  40'(err_e));
    check({tag, "_hold"},  40'(cpu_hold),  40'(hold_e));
    check({tag, "_state"}, 40'(dbg_state), 40'(st_e));
  endtask

  logic [31:0] w;
  logic [7:0]  chk;
  logic [7:0]  idx;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 40'(in_ready), 40'd0);
    check("rst_im_we",    40'(im_we),    40'd0);
    check("rst_waddr",    40'(im_waddr), 40'd0);
    check("rst_wdata",    40'(im_wdata), 40'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, LD_IDLE);
    rst_n = 1'b1;

    // N=2 good load; XOR of the data bytes is 20^08^00^05^8C^09^00^04 = AC
    pulse_start();
    check("start_hold", 40'(cpu_hold), 40'd1);
    check("start_state", 40'(dbg_state), 40'(LD_LEN_HI));
    exp_q.push_back({8'd0, 32'h2008_0005});
    exp_q.push_back({8'd1, 32'h8C09_0004});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h8C09_0004, 1);
    send_byte(8'hAC, 0);
    check_status("good", 1'b1, 1'b0, 1'b0, LD_DONE);
    check("good_drained", 40'(exp_q.size()), 40'd0);

    // Same frame, bad checksum: words still written, error, core held
    pulse_start();
    exp_q.push_back({8'd0, 32'h2008_0005});
    exp_q.push_back({8'd1, 32'h8C09_0004});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h8C09_0004, 0);
    send_byte(8'h00, 0);
    check_status("badchk", 1'b0, 1'b1, 1'b1, LD_ERR);
    check("badchk_drained", 40'(exp_q.size()), 40'd0);

    // Oversize N=257: rejected right after LEN_LO, nothing written
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("over_ready", 40'(in_ready), 40'd0);
    check_status("over", 1'b0, 1'b1, 1'b1, LD_ERR);

    // N=0: straight to checksum 00, done with no writes
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_status("zero", 1'b1, 1'b0, 1'b0, LD_DONE);

    // start during DATA is ignored; checksum 11^22^33^44 = 44
    pulse_start();
    exp_q.push_back({8'd0, 32'h1122_3344});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    check("data_start_state", 40'(dbg_state), 40'(LD_DATA));
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    check_status("ign", 1'b1, 1'b0, 1'b0, LD_DONE);

    // start in DONE with a byte offered: byte not taken, done cleared
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("restart_done", 40'(load_done), 40'd0);
    check("restart_state", 40'(dbg_state), 40'(LD_LEN_HI));
    check("restart_hold", 40'(cpu_hold), 40'd1);

    // Full 256-word load with random source gaps
    chk = 8'h00;
    send_byte(8'h01, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3));
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      w   = {idx, ~idx, 8'hA5, idx ^ 8'h3C};
      chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_q.push_back({idx, w});
      send_word(w, $urandom_range(0, 3));
    end
    send_byte(chk, $urandom_range(0, 3));
    check_status("full", 1'b1, 1'b0, 1'b0, LD_DONE);
    check("full_drained", 40'(exp_q.size()), 40'd0);

    // Reset held two cycles mid-DATA: outputs cleared, no further writes
    pulse_start();
    exp_q.push_back({8'd0, 32'hDEAD_BEEF});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", 40'(in_ready), 40'd0);
    check("mid_rst_we",    40'(im_we),    40'd0);
    check("mid_rst_waddr", 40'(im_waddr), 40'd0);
    check("mid_rst_wdata", 40'(im_wdata), 40'd0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, LD_IDLE);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h34;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_state", 40'(dbg_state), 40'(LD_IDLE));
    check("post_rst_drained", 40'(exp_q.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
